alarm_player: RTL and testbench

ALARM_PLAYER -- requirements
Module: alarm_player

---
 rtl/alarm_player_if.sv | 31 +++
 rtl/alarm_player.sv | 139 +++++++++++++
 tb/tb_alarm_player.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/alarm_player_if.sv
// Signal bundle between an alarm setter and the melody player.
// The setter drives the play/stop levels; the player returns tone and progress.
interface alarm_player_if;
    logic       alarm_do;
    logic       middle;
    logic       buzzer;
    logic       playing;
    logic [2:0] note_idx;
    logic [3:0] loop_cnt;
    logic       done;

    modport master (
        output alarm_do,
        output middle,
        input  buzzer,
        input  playing,
        input  note_idx,
        input  loop_cnt,
        input  done
    );

    modport slave (
        input  alarm_do,
        input  middle,
        output buzzer,
        output playing,
        output note_idx,
        output loop_cnt,
        output done
    );
endinterface

// File: rtl/alarm_player.sv
// Eight-note square-wave alarm melody, repeated LOOPS times per rising edge of alarm_do.
// A rising edge of middle aborts playback; all outputs are registered.
module alarm_player #(
    parameter int unsigned NOTE_CYCLES = 240,
    parameter int unsigned GAP_CYCLES  = 24,
    parameter int unsigned LOOPS       = 3
) (
    input logic            newclk,
    input logic            rst,
    alarm_player_if.slave  bus
);
    localparam int unsigned MaxCyc = (NOTE_CYCLES > GAP_CYCLES) ? NOTE_CYCLES : GAP_CYCLES;
    localparam int unsigned CycW   = $clog2(MaxCyc);

    typedef enum logic [1:0] {StIdle, StPlay, StGap} state_e;

    state_e           state_q;
    logic             do_q, middle_q;
    logic [CycW-1:0]  cyc_q;
    logic [2:0]       tone_q;
    logic             buzzer_q, playing_q, done_q;
    logic [2:0]       note_idx_q;
    logic [3:0]       loop_cnt_q;

    logic             do_rise, stop_rise;
    logic [2:0]       half;

    // Half-period per note; zero marks a rest.
    function automatic logic [2:0] half_rom(input logic [2:0] idx);
        case (idx)
            3'd0:    return 3'd6;
            3'd1:    return 3'd5;
            3'd2:    return 3'd4;
            3'd3:    return 3'd4;
            3'd4:    return 3'd3;
            3'd5:    return 3'd3;
            3'd6:    return 3'd2;
            default: return 3'd0;
        endcase
    endfunction

    assign do_rise   = bus.alarm_do & ~do_q;
    assign stop_rise = bus.middle & ~middle_q;
    assign half      = half_rom(note_idx_q);

    always_ff @(posedge newclk) begin
        if (rst) begin
            state_q    <= StIdle;
            do_q       <= 1'b1;
            middle_q   <= 1'b1;
            cyc_q      <= '0;
            tone_q     <= '0;
            buzzer_q   <= 1'b0;
            playing_q  <= 1'b0;
            note_idx_q <= '0;
            loop_cnt_q <= '0;
            done_q     <= 1'b0;
        end else begin
            do_q     <= bus.alarm_do;
            middle_q <= bus.middle;
            done_q   <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    // A stop edge in the same cycle suppresses the trigger.
                    if (do_rise && !stop_rise) begin
                        state_q    <= StPlay;
                        cyc_q      <= '0;
                        tone_q     <= '0;
                        buzzer_q   <= 1'b0;
                        playing_q  <= 1'b1;
                        note_idx_q <= '0;
                        loop_cnt_q <= '0;
                    end
                end
                StPlay: begin
                    if (stop_rise) begin
                        state_q    <= StIdle;
                        cyc_q      <= '0;
                        tone_q     <= '0;
                        buzzer_q   <= 1'b0;
                        playing_q  <= 1'b0;
                        note_idx_q <= '0;
                        loop_cnt_q <= '0;
                    end else if (cyc_q == CycW'(NOTE_CYCLES - 1)) begin
                        state_q  <= StGap;
                        cyc_q    <= '0;
                        tone_q   <= '0;
                        buzzer_q <= 1'b0;
                    end else begin
                        cyc_q <= cyc_q + CycW'(1);
                        if (half != 3'd0) begin
                            if (tone_q == half - 3'd1) begin
                                tone_q   <= '0;
                                buzzer_q <= ~buzzer_q;
                            end else begin
                                tone_q <= tone_q + 3'd1;
                            end
                        end
                    end
                end
                StGap: begin
                    if (stop_rise) begin
                        state_q    <= StIdle;
                        cyc_q      <= '0;
                        playing_q  <= 1'b0;
                        note_idx_q <= '0;
                        loop_cnt_q <= '0;
                    end else if (cyc_q == CycW'(GAP_CYCLES - 1)) begin
                        cyc_q  <= '0;
                        tone_q <= '0;
                        if (note_idx_q != 3'd7) begin
                            state_q    <= StPlay;
                            note_idx_q <= note_idx_q + 3'd1;
                        end else if (loop_cnt_q != 4'(LOOPS - 1)) begin
                            state_q    <= StPlay;
                            note_idx_q <= '0;
                            loop_cnt_q <= loop_cnt_q + 4'd1;
                        end else begin
                            state_q    <= StIdle;
                            playing_q  <= 1'b0;
                            note_idx_q <= '0;
                            loop_cnt_q <= '0;
                            done_q     <= 1'b1;
                        end
                    end else begin
                        cyc_q <= cyc_q + CycW'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.buzzer   = buzzer_q;
    assign bus.playing  = playing_q;
    assign bus.note_idx = note_idx_q;
    assign bus.loop_cnt = loop_cnt_q;
    assign bus.done     = done_q;
endmodule

// File: tb/tb_alarm_player.sv
// Bench for alarm_player: a timeline model (elapsed cycles since start) checked every cycle,
// plus directed literal expectations and a randomized phase.
module tb_alarm_player;
    localparam int unsigned NC    = 8;
    localparam int unsigned GC    = 2;
    localparam int unsigned LP    = 2;
    localparam int unsigned P     = NC + GC;
    localparam int unsigned LOOPL = 8 * P;
    localparam int unsigned TOTAL = LOOPL * LP;

    logic newclk = 1'b0;
    logic rst    = 1'b1;

    alarm_player_if bus ();

    alarm_player #(
        .NOTE_CYCLES(NC),
        .GAP_CYCLES (GC),
        .LOOPS      (LP)
    ) dut (
        .newclk(newclk),
        .rst   (rst),
        .bus   (bus)
    );

    always #5 newclk = ~newclk;

    int checks = 0;
    int passes = 0;

    int  half_tab [8] = '{6, 5, 4, 4, 3, 3, 2, 0};
    bit  armed    = 1'b0;
    bit  m_active = 1'b0;
    bit  m_done   = 1'b0;
    bit  prev_do  = 1'b1;
    bit  prev_mid = 1'b1;
    int  m_k      = 0;

    // Model: a run is just a count of elapsed cycles since its first PLAY cycle.
    always @(posedge newclk) begin
        if (rst) begin
            m_active = 1'b0;
            m_done   = 1'b0;
            m_k      = 0;
            prev_do  = 1'b1;
            prev_mid = 1'b1;
            armed    = 1'b1;
        end else begin
            bit do_rise, mid_rise;
            do_rise  = bus.alarm_do && !prev_do;
            mid_rise = bus.middle && !prev_mid;
            m_done   = 1'b0;
            if (m_active) begin
                if (mid_rise) begin
                    m_active = 1'b0;
                end else begin
                    m_k++;
                    if (m_k == TOTAL) begin
                        m_active = 1'b0;
                        m_done   = 1'b1;
                    end
                end
            end else if (do_rise && !mid_rise) begin
                m_active = 1'b1;
                m_k      = 0;
            end
            prev_do  = bus.alarm_do;
            prev_mid = bus.middle;
        end
    end

    int cyc_no = 0;
    always @(negedge newclk) begin
        int e_note, e_loop, pos, h;
        bit e_buz;
        cyc_no++;
        if (armed) begin
            e_note = m_active ? (m_k % LOOPL) / P : 0;
            e_loop = m_active ? m_k / LOOPL : 0;
            pos    = m_k % P;
            h      = half_tab[e_note];
            e_buz  = m_active && (pos < NC) && (h != 0) && (((pos / h) % 2) == 1);
            checks++;
            if (bus.playing === m_active && bus.note_idx === 3'(e_note) &&
                bus.loop_cnt === 4'(e_loop) && bus.buzzer === e_buz && bus.done === m_done) begin
                passes++;
            end else begin
                $display("FAIL model cycle %0d: got play=%0b note=%0d loop=%0d buz=%0b done=%0b, expected play=%0b note=%0d loop=%0d buz=%0b done=%0b",
                         cyc_no, bus.playing, bus.note_idx, bus.loop_cnt, bus.buzzer, bus.done,
                         m_active, e_note, e_loop, e_buz, m_done);
            end
        end
    end

    task automatic expect_val(input string name, input int got, input int exp);
        checks++;
        if (got == exp) passes++;
        else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    endtask

    initial begin
        bus.alarm_do = 1'b0;
        bus.middle   = 1'b0;
        rst          = 1'b1;
        repeat (3) @(negedge newclk);
        expect_val("reset playing", int'(bus.playing), 0);
        expect_val("reset buzzer", int'(bus.buzzer), 0);
        expect_val("reset done", int'(bus.done), 0);
        rst = 1'b0;
        repeat (2) @(negedge newclk);

        // Full natural run, alarm_do held high throughout.
        bus.alarm_do = 1'b1;
        for (int j = 1; j <= 170; j++) begin
            @(negedge newclk);
            if (j == 1) begin
                expect_val("start playing", int'(bus.playing), 1);
                expect_val("start note", int'(bus.note_idx), 0);
                expect_val("start buzzer", int'(bus.buzzer), 0);
            end
            if (j == 6)   expect_val("note0 low N+6", int'(bus.buzzer), 0);
            if (j == 7)   expect_val("note0 high N+7", int'(bus.buzzer), 1);
            if (j == 8)   expect_val("note0 high N+8", int'(bus.buzzer), 1);
            if (j == 9)   expect_val("gap low N+9", int'(bus.buzzer), 0);
            if (j == 11)  expect_val("note1 at N+11", int'(bus.note_idx), 1);
            if (j == 71)  expect_val("note7 at N+71", int'(bus.note_idx), 7);
            if (j == 76)  expect_val("rest silent", int'(bus.buzzer), 0);
            if (j == 80)  expect_val("loop0 at N+80", int'(bus.loop_cnt), 0);
            if (j == 81)  expect_val("loop1 at N+81", int'(bus.loop_cnt), 1);
            if (j == 160) expect_val("playing N+160", int'(bus.playing), 1);
            if (j == 161) begin
                expect_val("done N+161", int'(bus.done), 1);
                expect_val("idle N+161", int'(bus.playing), 0);
            end
            if (j == 162) expect_val("done one pulse", int'(bus.done), 0);
            if (j == 170) expect_val("no retrigger", int'(bus.playing), 0);
        end

        // Stop mid-run with middle.
        bus.alarm_do = 1'b0;
        repeat (2) @(negedge newclk);
        bus.alarm_do = 1'b1;
        for (int j = 1; j <= 40; j++) begin
            @(negedge newclk);
            if (j == 31) begin
                expect_val("stop playing", int'(bus.playing), 0);
                expect_val("stop buzzer", int'(bus.buzzer), 0);
                expect_val("stop no done", int'(bus.done), 0);
            end
            if (j == 40) expect_val("stop no restart", int'(bus.playing), 0);
            if (j == 30) bus.middle = 1'b1;
        end
        bus.middle   = 1'b0;
        bus.alarm_do = 1'b0;
        repeat (2) @(negedge newclk);

        // Simultaneous trigger and stop: stop wins.
        bus.alarm_do = 1'b1;
        bus.middle   = 1'b1;
        repeat (3) @(negedge newclk);
        expect_val("stop beats trigger", int'(bus.playing), 0);
        bus.alarm_do = 1'b0;
        bus.middle   = 1'b0;
        @(negedge newclk);
        bus.alarm_do = 1'b1;
        for (int j = 1; j <= 60; j++) begin
            @(negedge newclk);
            if (j == 1) expect_val("rearm start", int'(bus.playing), 1);
            if (j == 46) begin
                expect_val("rst playing", int'(bus.playing), 0);
                expect_val("rst note", int'(bus.note_idx), 0);
                expect_val("rst loop", int'(bus.loop_cnt), 0);
                rst = 1'b0;
            end
            if (j == 60) expect_val("rst no restart", int'(bus.playing), 0);
            if (j == 45) rst = 1'b1;
        end
        bus.alarm_do = 1'b0;
        @(negedge newclk);
        bus.alarm_do = 1'b1;
        @(negedge newclk);
        expect_val("rst rearm", int'(bus.playing), 1);

        // Randomized phase.
        for (int i = 0; i < 15000; i++) begin
            @(negedge newclk);
            rst = ($urandom_range(0, 1499) == 0);
            if ($urandom_range(0, 39) == 0) bus.alarm_do = ~bus.alarm_do;
            if ($urandom_range(0, 249) == 0) bus.middle = 1'b1;
            else if (bus.middle && $urandom_range(0, 3) == 0) bus.middle = 1'b0;
        end
        rst = 1'b0;
        @(negedge newclk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
